simon_control: RTL and testbench

Sequencing controller for the SIMON block-cipher core. It sits between the host handshake signals and the round/key-schedule datapath. It detects new-key and new-data requests, issues one-cycle load strobes, and drives the round counter during key expansion and encryption/decryption. It then captures the datapath result and holds it until the host acknowledges the read.

---
 rtl/simon_control_pkg.sv | 27 ++
 rtl/simon_control_if.sv | 46 ++++
 rtl/simon_control_rise.sv | 26 ++
 rtl/simon_control.sv | 126 ++++++++++++
 tb/tb_simon_control.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/simon_control_pkg.sv
// Shared constants, state encoding and reference vectors
// for the SIMON sequencing controller.
package simon_control_pkg;

  localparam int N_DEF = 16;
  localparam int M_DEF = 4;
  localparam int T_DEF = 32;

  // infoIN bit selecting decryption
  localparam int DEC_BIT = 0;

  typedef enum logic [2:0] {
    NOKEY,
    KLOAD,
    KEXP,
    DONE,
    READY,
    DLOAD,
    RUN
  } state_e;

  // SIMON32/64 reference vectors
  localparam logic [63:0] KEY_VEC = 64'h1918_1110_0908_0100;
  localparam logic [31:0] PT_VEC  = 32'h6565_6877;
  localparam logic [31:0] CT_VEC  = 32'hc69b_e9bb;

endpackage

// File: rtl/simon_control_if.sv
// Host/datapath signal bundle of the SIMON controller.
// master = host side, slave = controller side.
interface simon_control_if
  import simon_control_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
);

  logic           newDATA;
  logic           newKEY;
  logic           readDATA;
  logic [7:0]     infoIN;
  logic [7:0]     countIN;
  logic [2*N-1:0] inDATA;
  logic [M*N-1:0] KEY;

  logic           newDATA_rise;
  logic           newKEY_rise;
  logic           loadDATA;
  logic           loadKEY;
  logic           doneDATA;
  logic           doneKEY;
  logic [7:0]     infoOUT;
  logic [7:0]     countOUT;
  logic [2*N-1:0] outDATA;

  modport master (
    output newDATA, newKEY, readDATA,
    output infoIN, countIN, inDATA, KEY,
    input  newDATA_rise, newKEY_rise,
    input  loadDATA, loadKEY,
    input  doneDATA, doneKEY,
    input  infoOUT, countOUT, outDATA
  );

  modport slave (
    input  newDATA, newKEY, readDATA,
    input  infoIN, countIN, inDATA, KEY,
    output newDATA_rise, newKEY_rise,
    output loadDATA, loadKEY,
    output doneDATA, doneKEY,
    output infoOUT, countOUT, outDATA
  );

endinterface

// File: rtl/simon_control_rise.sv
// Registered rising-edge pulse generator:
// one-cycle pulse the edge after x_i goes high.
module simon_rise_detect (
  input  logic clk,
  input  logic nR,
  input  logic x_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  // track previous level and register the edge pulse
  always_ff @(posedge clk) begin
    if (nR) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= x_i;
      rise_q <= x_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/simon_control.sv
// Sequencer for the SIMON round/key datapath:
// key load, key expansion, block run and result hold.
module simon_control
  import simon_control_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int T = T_DEF
) (
  input  logic            clk,
  input  logic            nR,
  simon_control_if.slave  bus
);

  localparam logic [7:0] LAST = 8'(T - 1);
  localparam logic [7:0] KSTART = 8'(M);

  state_e         state_q, state_d;
  logic           dkey_q, dkey_d;
  logic [7:0]     info_q, info_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [2*N-1:0] out_q, out_d;

  logic           data_rise;
  logic           key_rise;
  logic [7:0]     c_clamp;
  logic           run_dec;
  logic           unused_key;

  assign unused_key = ^bus.KEY;

  simon_rise_detect u_rise_data (
    .clk    (clk),
    .nR     (nR),
    .x_i    (bus.newDATA),
    .rise_o (data_rise)
  );

  simon_rise_detect u_rise_key (
    .clk    (clk),
    .nR     (nR),
    .x_i    (bus.newKEY),
    .rise_o (key_rise)
  );

  assign c_clamp = (bus.countIN >= 8'(T)) ? 8'd0 : bus.countIN;
  assign run_dec = info_q[DEC_BIT];

  // state and datapath-facing registers
  always_ff @(posedge clk) begin
    if (nR) begin
      state_q <= NOKEY;
      dkey_q  <= 1'b0;
      info_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      dkey_q  <= dkey_d;
      info_q  <= info_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // next-state, round counter and result capture
  always_comb begin
    state_d = state_q;
    dkey_d  = dkey_q;
    info_d  = info_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      NOKEY: begin
        if (key_rise) state_d = KLOAD;
      end
      KLOAD: begin
        dkey_d  = 1'b0;
        cnt_d   = KSTART;
        state_d = KEXP;
      end
      KEXP: begin
        if (cnt_q == LAST) begin
          dkey_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (key_rise)          state_d = KLOAD;
        else if (bus.readDATA) state_d = READY;
      end
      READY: begin
        if (key_rise)       state_d = KLOAD;
        else if (data_rise) state_d = DLOAD;
      end
      DLOAD: begin
        info_d  = bus.infoIN;
        cnt_d   = bus.infoIN[DEC_BIT] ? LAST - c_clamp
                                      : c_clamp;
        state_d = RUN;
      end
      RUN: begin
        if (run_dec ? (cnt_q == 8'd0) : (cnt_q == LAST)) begin
          out_d   = bus.inDATA;
          state_d = DONE;
        end else begin
          cnt_d = run_dec ? cnt_q - 8'd1 : cnt_q + 8'd1;
        end
      end
      default: state_d = NOKEY;
    endcase
  end

  assign bus.newDATA_rise = data_rise;
  assign bus.newKEY_rise  = key_rise;
  assign bus.loadKEY      = (state_q == KLOAD);
  assign bus.loadDATA     = (state_q == DLOAD);
  assign bus.doneDATA     = (state_q == DONE);
  assign bus.doneKEY      = dkey_q;
  assign bus.infoOUT      = info_q;
  assign bus.countOUT     = cnt_q;
  assign bus.outDATA      = out_q;

endmodule

// File: tb/tb_simon_control.sv
// Directed bench for simon_control: table of block
// operations plus key-load, conflict and reset sequences.
module tb_simon_control;
  import simon_control_pkg::*;

  typedef struct {
    logic [7:0] info;
    logic [7:0] cin;
    logic [7:0] first;
    int         cycles;
  } vec_t;

  logic clk;
  logic nR;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[8];

  simon_control_if #(.N(N_DEF), .M(M_DEF)) bus ();

  simon_control #(
    .N(N_DEF),
    .M(M_DEF),
    .T(T_DEF)
  ) dut (
    .clk (clk),
    .nR  (nR),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_drise"}, bus.newDATA_rise, 0);
    chk({tag, "_krise"}, bus.newKEY_rise, 0);
    chk({tag, "_ldata"}, bus.loadDATA, 0);
    chk({tag, "_lkey"}, bus.loadKEY, 0);
    chk({tag, "_ddata"}, bus.doneDATA, 0);
    chk({tag, "_dkey"}, bus.doneKEY, 0);
    chk({tag, "_info"}, bus.infoOUT, 0);
    chk({tag, "_cnt"}, bus.countOUT, 0);
    chk({tag, "_out"}, bus.outDATA, 0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(NOKEY));
  endtask

  task automatic read_ack();
    bus.readDATA = 1'b1;
    step();
    chk("ack_ddata", bus.doneDATA, 0);
    bus.readDATA = 1'b0;
  endtask

  task automatic key_load(input bit with_data);
    int cyc;
    int nld;
    bus.newKEY = 1'b1;
    if (with_data) bus.newDATA = 1'b1;
    step();
    chk("key_rise", bus.newKEY_rise, 1);
    chk("lkey_early", bus.loadKEY, 0);
    step();
    chk("lkey_pulse", bus.loadKEY, 1);
    chk("lkey_nodata", bus.loadDATA, 0);
    bus.newKEY = 1'b0;
    bus.newDATA = 1'b0;
    step();
    chk("lkey_fall", bus.loadKEY, 0);
    chk("kexp_start", bus.countOUT, M_DEF);
    chk("dkey_clr", bus.doneKEY, 0);
    cyc = 0;
    nld = 0;
    while (!bus.doneKEY && cyc < 100) begin
      if (bus.loadDATA) nld++;
      step();
      cyc++;
    end
    chk("kexp_len", cyc, T_DEF - M_DEF);
    chk("kexp_ddata", bus.doneDATA, 1);
    chk("kexp_last", bus.countOUT, T_DEF - 1);
    chk("kexp_ldata", nld, 0);
  endtask

  task automatic run_block(input vec_t v);
    logic [31:0] last;
    logic [31:0] val;
    logic [7:0]  ec;
    int          cyc;
    bit          dec;
    read_ack();
    dec = v.info[DEC_BIT];
    bus.infoIN = v.info;
    bus.countIN = v.cin;
    bus.newDATA = 1'b1;
    step();
    chk("blk_rise", bus.newDATA_rise, 1);
    chk("blk_ld_early", bus.loadDATA, 0);
    step();
    chk("blk_ld", bus.loadDATA, 1);
    bus.newDATA = 1'b0;
    step();
    chk("blk_ld_fall", bus.loadDATA, 0);
    chk("blk_info", bus.infoOUT, v.info);
    ec = v.first;
    cyc = 0;
    last = '0;
    while (!bus.doneDATA && cyc < 300) begin
      chk("run_cnt", bus.countOUT, ec);
      val = $urandom;
      bus.inDATA = val;
      last = val;
      step();
      cyc++;
      ec = dec ? ec - 8'd1 : ec + 8'd1;
    end
    chk("run_len", cyc, v.cycles);
    chk("run_out", bus.outDATA, last);
    chk("run_final", bus.countOUT, dec ? 0 : T_DEF - 1);
    chk("run_dkey", bus.doneKEY, 1);
  endtask

  initial begin
    int nld;
    int cyc;
    tbl[0] = '{8'h00, 8'd0,   8'd0,  32};
    tbl[1] = '{8'h01, 8'd0,   8'd31, 32};
    tbl[2] = '{8'h00, 8'd30,  8'd30, 2};
    tbl[3] = '{8'h00, 8'd200, 8'd0,  32};
    tbl[4] = '{8'hA5, 8'd5,   8'd26, 27};
    tbl[5] = '{8'h00, 8'd31,  8'd31, 1};
    tbl[6] = '{8'h01, 8'd32,  8'd31, 32};
    tbl[7] = '{8'h80, 8'd16,  8'd16, 16};

    bus.newDATA = 1'b0;
    bus.newKEY = 1'b0;
    bus.readDATA = 1'b0;
    bus.infoIN = 8'h00;
    bus.countIN = 8'h00;
    bus.inDATA = PT_VEC;
    bus.KEY = KEY_VEC;
    nR = 1'b1;
    step();
    step();
    chk_zero("rst");
    nR = 1'b0;

    bus.newDATA = 1'b1;
    step();
    chk("nokey_rise", bus.newDATA_rise, 1);
    chk("nokey_ld0", bus.loadDATA, 0);
    step();
    chk("nokey_rise1", bus.newDATA_rise, 0);
    chk("nokey_ld1", bus.loadDATA, 0);
    step();
    chk("nokey_state", 32'(dut.state_q), 32'(NOKEY));
    bus.newDATA = 1'b0;
    step();

    key_load(1'b0);

    for (int i = 0; i < 8; i++) run_block(tbl[i]);

    read_ack();
    key_load(1'b1);

    read_ack();
    bus.infoIN = 8'h00;
    bus.countIN = 8'd0;
    bus.newDATA = 1'b1;
    nld = 0;
    cyc = 0;
    step();
    while (!bus.doneDATA && cyc < 60) begin
      if (bus.loadDATA) nld++;
      step();
      cyc++;
    end
    chk("hold_ddata", bus.doneDATA, 1);
    read_ack();
    for (int i = 0; i < 4; i++) begin
      if (bus.loadDATA) nld++;
      step();
    end
    chk("hold_one_ld", nld, 1);
    chk("hold_ready", bus.doneDATA, 0);
    bus.newDATA = 1'b0;
    step();

    bus.infoIN = 8'hA5;
    bus.countIN = 8'd0;
    bus.newDATA = 1'b1;
    step();
    step();
    bus.newDATA = 1'b0;
    step();
    step();
    step();
    chk("mid_run_dkey", bus.doneKEY, 1);
    chk("mid_run_info", bus.infoOUT, 8'hA5);
    nR = 1'b1;
    step();
    chk_zero("mid_rst");
    nR = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
